// File: rtl/i2c_init_sequencer.sv
// Table-driven I2C bring-up sequencer: walks a synchronous command ROM and
// issues writes, polled reads and timed delays through the I2C master's
// ready/valid transaction port, reporting done plus a sticky error code.
module i2c_init_sequencer #(
  parameter logic [6:0]  DEVICE_ADDRESS = 7'h00,
  parameter int unsigned INDEX_WIDTH    = 8,
  parameter int unsigned DELAY_CYCLES   = 1000,
  parameter int unsigned RETRY_LIMIT    = 3,
  parameter int unsigned POLL_LIMIT     = 255
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [1:0]             error_code,
  output logic [INDEX_WIDTH-1:0] error_index,
  output logic [INDEX_WIDTH-1:0] rom_address,
  input  logic [17:0]            rom_data,
  output logic                   i2c_ready,
  output logic [6:0]             i2c_address,
  output logic                   i2c_rw,
  output logic [7:0]             i2c_register,
  output logic [7:0]             i2c_data_write,
  input  logic                   i2c_valid,
  input  logic                   i2c_nack,
  input  logic [7:0]             i2c_data_read
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_ISSUE  = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DELAY  = 3'd5;
  localparam logic [2:0] S_FINISH = 3'd6;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_POLL  = 2'd1;
  localparam logic [1:0] OP_DELAY = 2'd2;

  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_POLL    = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam logic [7:0]             RETRY_MAX  = 8'(RETRY_LIMIT);
  localparam logic [7:0]             POLL_MAX   = 8'(POLL_LIMIT);
  localparam logic [31:0]            DELAY_UNIT = 32'(DELAY_CYCLES);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = '1;
  localparam logic [INDEX_WIDTH-1:0] INDEX_ONE  = INDEX_WIDTH'(1);

  logic [2:0]             state_q, state_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [INDEX_WIDTH-1:0] rom_address_q, rom_address_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [1:0]             error_code_q, error_code_d;
  logic [INDEX_WIDTH-1:0] error_index_q, error_index_d;
  logic                   ready_q, ready_d;
  logic                   rw_q, rw_d;
  logic [7:0]             register_q, register_d;
  logic [7:0]             data_write_q, data_write_d;
  logic                   nack_q, nack_d;
  logic [7:0]             rdata_q, rdata_d;
  logic [7:0]             attempts_q, attempts_d;
  logic [7:0]             polls_q, polls_d;
  logic [31:0]            delay_count_q, delay_count_d;

  logic                   do_advance;
  logic                   do_fail;
  logic [1:0]             fail_code;

  // Next-state logic: sequencing FSM, then the shared advance/fail resolution.
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    rom_address_d = rom_address_q;
    busy_d        = busy_q;
    done_d        = done_q;
    error_d       = error_q;
    error_code_d  = error_code_q;
    error_index_d = error_index_q;
    ready_d       = ready_q;
    rw_d          = rw_q;
    register_d    = register_q;
    data_write_d  = data_write_q;
    nack_d        = nack_q;
    rdata_d       = rdata_q;
    attempts_d    = attempts_q;
    polls_d       = polls_q;
    delay_count_d = delay_count_q;
    do_advance    = 1'b0;
    do_fail       = 1'b0;
    fail_code     = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          index_d       = '0;
          rom_address_d = '0;
          error_d       = 1'b0;
          error_code_d  = '0;
          error_index_d = '0;
          busy_d        = 1'b1;
          state_d       = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (rom_data[17:16])
          OP_WRITE, OP_POLL: begin
            rw_d         = (rom_data[17:16] == OP_POLL);
            register_d   = rom_data[15:8];
            data_write_d = rom_data[7:0];
            attempts_d   = '0;
            polls_d      = '0;
            ready_d      = 1'b1;
            state_d      = S_ISSUE;
          end
          OP_DELAY: begin
            if (rom_data[7:0] != 8'd0) begin
              // Loaded with N-1 so DELAY residency is exactly N cycles.
              delay_count_d = 32'(rom_data[7:0]) * DELAY_UNIT - 32'd1;
              state_d       = S_DELAY;
            end else begin
              do_advance = 1'b1;
            end
          end
          default: begin
            done_d  = 1'b1;
            state_d = S_FINISH;
          end
        endcase
      end
      S_ISSUE: begin
        if (i2c_valid) begin
          nack_d  = i2c_nack;
          rdata_d = i2c_data_read;
          ready_d = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (nack_q) begin
          if (attempts_q < RETRY_MAX) begin
            attempts_d = attempts_q + 8'd1;
            ready_d    = 1'b1;
            state_d    = S_ISSUE;
          end else begin
            do_fail   = 1'b1;
            fail_code = ERR_NACK;
          end
        end else if (rw_q && (rdata_q != data_write_q)) begin
          if (polls_q < POLL_MAX) begin
            polls_d = polls_q + 8'd1;
            ready_d = 1'b1;
            state_d = S_ISSUE;
          end else begin
            do_fail   = 1'b1;
            fail_code = ERR_POLL;
          end
        end else begin
          do_advance = 1'b1;
        end
      end
      S_DELAY: begin
        if (delay_count_q == '0) begin
          do_advance = 1'b1;
        end else begin
          delay_count_d = delay_count_q - 32'd1;
        end
      end
      S_FINISH: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Advance can itself raise the overrun failure, so it resolves first.
    if (do_advance) begin
      if (index_q == LAST_INDEX) begin
        do_fail   = 1'b1;
        fail_code = ERR_OVERRUN;
      end else begin
        index_d       = index_q + INDEX_ONE;
        rom_address_d = index_q + INDEX_ONE;
        state_d       = S_FETCH;
      end
    end

    if (do_fail) begin
      error_d       = 1'b1;
      error_code_d  = fail_code;
      error_index_d = index_q;
      done_d        = 1'b1;
      state_d       = S_FINISH;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      index_q       <= '0;
      rom_address_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      error_code_q  <= '0;
      error_index_q <= '0;
      ready_q       <= 1'b0;
      rw_q          <= 1'b0;
      register_q    <= '0;
      data_write_q  <= '0;
      nack_q        <= 1'b0;
      rdata_q       <= '0;
      attempts_q    <= '0;
      polls_q       <= '0;
      delay_count_q <= '0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      rom_address_q <= rom_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      error_code_q  <= error_code_d;
      error_index_q <= error_index_d;
      ready_q       <= ready_d;
      rw_q          <= rw_d;
      register_q    <= register_d;
      data_write_q  <= data_write_d;
      nack_q        <= nack_d;
      rdata_q       <= rdata_d;
      attempts_q    <= attempts_d;
      polls_q       <= polls_d;
      delay_count_q <= delay_count_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign error_code     = error_code_q;
  assign error_index    = error_index_q;
  assign rom_address    = rom_address_q;
  assign i2c_ready      = ready_q;
  assign i2c_address    = DEVICE_ADDRESS;
  assign i2c_rw         = rw_q;
  assign i2c_register   = register_q;
  assign i2c_data_write = data_write_q;

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Directed scoreboard bench for i2c_init_sequencer: two instances (8-bit and
// 2-bit index, different poll limits) share one master model and a ROM each.
module tb_i2c_init_sequencer;

  logic clock = 1'b0;
  logic reset_n;
  logic start;
  logic sel;            // 0 = instance A, 1 = instance B

  // Master model drive
  logic       m_valid;
  logic       m_nack;
  logic [7:0] m_rdata;
  int unsigned m_lat;

  // Instance A signals
  logic        a_busy, a_done, a_error, a_ready, a_rw;
  logic [1:0]  a_code;
  logic [7:0]  a_eidx, a_rom_address, a_reg, a_wdata;
  logic [6:0]  a_addr;
  logic [17:0] a_rom_data;
  // Instance B signals
  logic        b_busy, b_done, b_error, b_ready, b_rw;
  logic [1:0]  b_code;
  logic [1:0]  b_eidx, b_rom_address;
  logic [7:0]  b_reg, b_wdata;
  logic [6:0]  b_addr;
  logic [17:0] b_rom_data;

  logic [17:0] rom_a [256];
  logic [17:0] rom_b [4];

  // Selected-instance view
  logic        m_busy, m_done, m_error, m_ready, m_rw;
  logic [1:0]  m_code;
  logic [7:0]  m_eidx, m_rom_address, m_reg, m_wdata;
  logic [6:0]  m_addr, m_exp_addr;

  assign m_busy        = sel ? b_busy  : a_busy;
  assign m_done        = sel ? b_done  : a_done;
  assign m_error       = sel ? b_error : a_error;
  assign m_ready       = sel ? b_ready : a_ready;
  assign m_rw          = sel ? b_rw    : a_rw;
  assign m_code        = sel ? b_code  : a_code;
  assign m_eidx        = sel ? {6'd0, b_eidx} : a_eidx;
  assign m_rom_address = sel ? {6'd0, b_rom_address} : a_rom_address;
  assign m_reg         = sel ? b_reg   : a_reg;
  assign m_wdata       = sel ? b_wdata : a_wdata;
  assign m_addr        = sel ? b_addr  : a_addr;
  assign m_exp_addr    = sel ? 7'h2C   : 7'h5A;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned n_trans  = 0;

  logic [16:0] exp_q [$];   // {rw, reg, data} expected per transaction
  logic [8:0]  rsp_q [$];   // {nack, read data} returned per transaction

  always #5 clock = ~clock;

  i2c_init_sequencer #(
    .DEVICE_ADDRESS(7'h5A), .INDEX_WIDTH(8), .DELAY_CYCLES(4),
    .RETRY_LIMIT(3), .POLL_LIMIT(255)
  ) u_dut_a (
    .clock(clock), .reset_n(reset_n), .start(start & ~sel),
    .busy(a_busy), .done(a_done), .error(a_error), .error_code(a_code),
    .error_index(a_eidx), .rom_address(a_rom_address), .rom_data(a_rom_data),
    .i2c_ready(a_ready), .i2c_address(a_addr), .i2c_rw(a_rw),
    .i2c_register(a_reg), .i2c_data_write(a_wdata),
    .i2c_valid(m_valid & ~sel), .i2c_nack(m_nack), .i2c_data_read(m_rdata)
  );

  i2c_init_sequencer #(
    .DEVICE_ADDRESS(7'h2C), .INDEX_WIDTH(2), .DELAY_CYCLES(4),
    .RETRY_LIMIT(3), .POLL_LIMIT(1)
  ) u_dut_b (
    .clock(clock), .reset_n(reset_n), .start(start & sel),
    .busy(b_busy), .done(b_done), .error(b_error), .error_code(b_code),
    .error_index(b_eidx), .rom_address(b_rom_address), .rom_data(b_rom_data),
    .i2c_ready(b_ready), .i2c_address(b_addr), .i2c_rw(b_rw),
    .i2c_register(b_reg), .i2c_data_write(b_wdata),
    .i2c_valid(m_valid & sel), .i2c_nack(m_nack), .i2c_data_read(m_rdata)
  );

  // Synchronous command ROMs (one cycle read latency)
  always @(posedge clock) begin
    a_rom_data <= rom_a[a_rom_address];
    b_rom_data <= rom_b[b_rom_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_tr(input logic rw, input logic [7:0] r, input logic [7:0] d,
                         input logic nack, input logic [7:0] rd);
    exp_q.push_back({rw, r, d});
    rsp_q.push_back({nack, rd});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic exp_err,
                           input logic [1:0] exp_code, input logic [7:0] exp_idx);
    int unsigned cyc = 0;
    while (m_done !== 1'b1 && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, "_done"}, {31'd0, m_done}, 32'd1);
    check({tag, "_error"}, {31'd0, m_error}, {31'd0, exp_err});
    check({tag, "_code"}, {30'd0, m_code}, {30'd0, exp_code});
    check({tag, "_index"}, {24'd0, m_eidx}, {24'd0, exp_idx});
    @(negedge clock);
    check({tag, "_done_pulse"}, {31'd0, m_done}, 32'd0);
    check({tag, "_busy_low"}, {31'd0, m_busy}, 32'd0);
    check({tag, "_error_sticky"}, {31'd0, m_error}, {31'd0, exp_err});
    check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_busy"}, {31'd0, a_busy}, 32'd0);
    check({tag, "_done"}, {31'd0, a_done}, 32'd0);
    check({tag, "_error"}, {31'd0, a_error}, 32'd0);
    check({tag, "_code"}, {30'd0, a_code}, 32'd0);
    check({tag, "_eidx"}, {24'd0, a_eidx}, 32'd0);
    check({tag, "_rom_addr"}, {24'd0, a_rom_address}, 32'd0);
    check({tag, "_ready"}, {31'd0, a_ready}, 32'd0);
    check({tag, "_rw"}, {31'd0, a_rw}, 32'd0);
    check({tag, "_reg"}, {24'd0, a_reg}, 32'd0);
    check({tag, "_wdata"}, {24'd0, a_wdata}, 32'd0);
    check({tag, "_addr"}, {25'd0, a_addr}, 32'h5A);
  endtask

  // I2C master model: accepts a request, answers after m_lat+1 cycles,
  // and checks the request against the scoreboard.
  initial begin
    int unsigned st = 0;
    int unsigned cnt = 0;
    logic [16:0] e;
    logic [8:0]  r;
    m_valid = 1'b0;
    m_nack  = 1'b0;
    m_rdata = '0;
    forever begin
      @(negedge clock);
      if (reset_n !== 1'b1) begin
        st = 0;
        m_valid = 1'b0;
      end else begin
        case (st)
          0: if (m_ready === 1'b1) begin
            n_trans++;
            check("tr_address", {25'd0, m_addr}, {25'd0, m_exp_addr});
            if (exp_q.size() == 0) begin
              check("tr_unexpected", 32'd1, 32'd0);
            end else begin
              e = exp_q.pop_front();
              check("tr_fields", {15'd0, m_rw, m_reg, m_wdata}, {15'd0, e});
            end
            cnt = m_lat;
            st = 1;
          end
          1: if (cnt > 0) begin
            cnt--;
          end else begin
            r = (rsp_q.size() != 0) ? rsp_q.pop_front() : 9'h000;
            m_nack  = r[8];
            m_rdata = r[7:0];
            m_valid = 1'b1;
            st = 2;
          end
          default: begin
            m_valid = 1'b0;
            check("ready_after_valid", {31'd0, m_ready}, 32'd0);
            st = 0;
          end
        endcase
      end
    end
  end

  initial begin
    int unsigned base;
    int unsigned t1, t2, tr;
    start = 1'b0;
    sel = 1'b0;
    m_lat = 1;
    reset_n = 1'b1;
    for (int i = 0; i < 256; i++) rom_a[i] = 18'h30000;
    for (int i = 0; i < 4; i++) rom_b[i] = 18'h30000;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_a("reset");
    check("reset_b_rom_addr", {30'd0, b_rom_address}, 32'd0);
    check("reset_b_addr", {25'd0, b_addr}, 32'h2C);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Two writes then END, with start-to-ready latency checks
    rom_a[0] = {2'd0, 8'h10, 8'hA5};
    rom_a[1] = {2'd0, 8'h11, 8'h3C};
    rom_a[2] = {2'd3, 16'h0000};
    push_tr(1'b0, 8'h10, 8'hA5, 1'b0, 8'h00);
    push_tr(1'b0, 8'h11, 8'h3C, 1'b0, 8'h00);
    base = n_trans;
    pulse_start();
    check("wr_c1_busy", {31'd0, a_busy}, 32'd1);
    check("wr_c1_rom_addr", {24'd0, a_rom_address}, 32'd0);
    @(negedge clock);
    check("wr_c2_ready", {31'd0, a_ready}, 32'd0);
    @(negedge clock);
    check("wr_c3_ready", {31'd0, a_ready}, 32'd1);
    wait_done("wr", 1'b0, 2'd0, 8'd0);
    check("wr_ntrans", n_trans - base, 32'd2);

    // NACK four times: retries exhausted
    rom_a[0] = {2'd0, 8'h30, 8'h11};
    rom_a[1] = {2'd3, 16'h0000};
    for (int i = 0; i < 4; i++) push_tr(1'b0, 8'h30, 8'h11, 1'b1, 8'h00);
    base = n_trans;
    pulse_start();
    wait_done("nack4", 1'b1, 2'd1, 8'd0);
    check("nack4_ntrans", n_trans - base, 32'd4);

    // NACK three times then ACK; a start re-pulse while busy is ignored
    for (int i = 0; i < 3; i++) push_tr(1'b0, 8'h30, 8'h11, 1'b1, 8'h00);
    push_tr(1'b0, 8'h30, 8'h11, 1'b0, 8'h00);
    base = n_trans;
    pulse_start();
    check("nack3_err_cleared", {31'd0, a_error}, 32'd0);
    repeat (4) @(negedge clock);
    pulse_start();
    wait_done("nack3", 1'b0, 2'd0, 8'd0);
    check("nack3_ntrans", n_trans - base, 32'd4);
    repeat (8) @(negedge clock);
    check("restart_ignored_busy", {31'd0, a_busy}, 32'd0);
    check("restart_ignored_ntrans", n_trans - base, 32'd4);

    // POLL with default limit: two mismatches then match
    rom_a[0] = {2'd1, 8'h20, 8'h80};
    rom_a[1] = {2'd3, 16'h0000};
    push_tr(1'b1, 8'h20, 8'h80, 1'b0, 8'h00);
    push_tr(1'b1, 8'h20, 8'h80, 1'b0, 8'h00);
    push_tr(1'b1, 8'h20, 8'h80, 1'b0, 8'h80);
    base = n_trans;
    pulse_start();
    wait_done("poll", 1'b0, 2'd0, 8'd0);
    check("poll_ntrans", n_trans - base, 32'd3);

    // DELAY 5 x 4 cycles, DELAY 0, then a write
    rom_a[0] = {2'd2, 8'h00, 8'd5};
    rom_a[1] = {2'd2, 8'h00, 8'd0};
    rom_a[2] = {2'd0, 8'h40, 8'h77};
    rom_a[3] = {2'd3, 16'h0000};
    push_tr(1'b0, 8'h40, 8'h77, 1'b0, 8'h00);
    t1 = 0; t2 = 0; tr = 0;
    pulse_start();
    for (int cyc = 1; cyc < 60 && tr == 0; cyc++) begin
      if (a_rom_address == 8'd1 && t1 == 0) t1 = cyc;
      if (a_rom_address == 8'd2 && t2 == 0) t2 = cyc;
      if (a_ready === 1'b1) tr = cyc;
      if (tr == 0) @(negedge clock);
    end
    check("delay5_fetch_cycle", t1, 32'd23);
    check("delay0_fetch_cycle", t2, 32'd25);
    check("delay_ready_cycle", tr, 32'd27);
    wait_done("delay", 1'b0, 2'd0, 8'd0);

    // Instance B: POLL_LIMIT=1 -> poll timeout after two reads
    sel = 1'b1;
    @(negedge clock);
    rom_b[0] = {2'd1, 8'h20, 8'h80};
    rom_b[1] = {2'd3, 16'h0000};
    push_tr(1'b1, 8'h20, 8'h80, 1'b0, 8'h00);
    push_tr(1'b1, 8'h20, 8'h80, 1'b0, 8'h00);
    base = n_trans;
    pulse_start();
    wait_done("polltmo", 1'b1, 2'd2, 8'd0);
    check("polltmo_ntrans", n_trans - base, 32'd2);

    // Instance B: four writes without END -> table overrun at index 3
    for (int i = 0; i < 4; i++) begin
      rom_b[i] = {2'd0, 8'(8'h50 + i), 8'(i + 1)};
      push_tr(1'b0, 8'(8'h50 + i), 8'(i + 1), 1'b0, 8'h00);
    end
    base = n_trans;
    pulse_start();
    check("ovr_err_cleared", {31'd0, b_error}, 32'd0);
    wait_done("ovr", 1'b1, 2'd3, 8'd3);
    check("ovr_ntrans", n_trans - base, 32'd4);

    // Instance A: reset asserted while a transaction is outstanding
    sel = 1'b0;
    @(negedge clock);
    rom_a[0] = {2'd0, 8'h60, 8'hAA};
    rom_a[1] = {2'd3, 16'h0000};
    push_tr(1'b0, 8'h60, 8'hAA, 1'b0, 8'h00);
    m_lat = 50;
    pulse_start();
    for (int i = 0; i < 20 && a_ready !== 1'b1; i++) @(negedge clock);
    check("rst_reached_issue", {31'd0, a_ready}, 32'd1);
    check("rst_issue_reg", {24'd0, a_reg}, 32'h60);
    #2 reset_n = 1'b0;
    #1 check_reset_a("async_rst");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    m_lat = 1;
    exp_q.delete();
    rsp_q.delete();
    @(negedge clock);

    // Fresh start after reset runs from index 0
    push_tr(1'b0, 8'h60, 8'hAA, 1'b0, 8'h00);
    base = n_trans;
    pulse_start();
    check("post_rst_rom_addr", {24'd0, a_rom_address}, 32'd0);
    check("post_rst_busy", {31'd0, a_busy}, 32'd1);
    wait_done("post_rst", 1'b0, 2'd0, 8'd0);
    check("post_rst_ntrans", n_trans - base, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
